// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its round-robin selector.
//   arb_state_t     : arbiter FSM state encoding
//   clog2()         : ceiling log2 for sizing index and counter fields
//   DEFAULT_DATA_W  : data width shared with sync_fifo
package fifo_arb_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Searches req starting at index ptr and wrapping modulo N; reports the first
// set bit found.
//   req   : request vector
//   ptr   : search start index (0..N-1)
//   found : at least one request is set
//   idx   : index of the first set request at or after ptr (wrapping)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    int cand;

    // Walk from the farthest candidate back to ptr so the nearest hit is the
    // last one assigned and therefore wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand[ID_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port among N_REQ
// producers. One requester is granted at a time for up to MAX_BURST beats;
// all producers are back-pressured while the FIFO is full.
//   clk        : clock
//   reset      : asynchronous active-low reset
//   req_valid  : per-requester data valid
//   req_data   : packed data, requester i at [i*DATA_W +: DATA_W]
//   req_last   : per-requester end-of-burst marker
//   req_ready  : per-requester accept (beat = valid & ready)
//   fifo_full  : FIFO full flag
//   fifo_wr_en : FIFO write enable
//   fifo_wdata : FIFO write data
//   grant_id   : current or most recently granted requester
//   busy       : high while a grant is active
//
// state | meaning
// IDLE  | no grant; pick next requester round-robin from rr_ptr
// GRANT | grant_id owns the FIFO write port until last/limit/bubble
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int   N_REQ     = 4,
    parameter int   DATA_W    = DEFAULT_DATA_W,
    parameter int   MAX_BURST = 4,
    localparam int  ID_W      = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_wdata,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
);

    localparam int CNT_W = clog2(MAX_BURST + 1);

    arb_state_t       state, state_d;
    logic [ID_W-1:0]  rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_d;
    logic [ID_W-1:0]  grant_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic             granted_valid;
    logic             granted_last;
    logic [DATA_W-1:0] granted_data;
    logic [CNT_W-1:0] beat_inc;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign granted_valid = req_valid[grant_id];
    assign granted_last  = req_last[grant_id];
    assign granted_data  = req_data[int'(grant_id)*DATA_W +: DATA_W];
    assign beat_inc      = beat_cnt + CNT_W'(1);
    assign next_ptr      = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign busy          = (state == GRANT);

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        beat_cnt_d = beat_cnt;
        grant_d    = grant_id;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_wdata = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_id] = !fifo_full;
                fifo_wr_en          = granted_valid & !fifo_full;
                fifo_wdata          = granted_data;
                // A bubble ends the grant even while the FIFO is full;
                // full alone only stalls.
                if (!granted_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (!fifo_full) begin
                    beat_cnt_d = beat_inc;
                    if (granted_last || (beat_inc == CNT_W'(MAX_BURST))) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            beat_cnt <= beat_cnt_d;
            grant_id <= grant_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_wdata;
    logic [1:0]              grant_id;
    logic                    busy;

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]            = v;
        req_data[i*DATA_W +: 8] = d;
        req_last[i]             = l;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        fifo_full = 1'b0;
        clear_reqs();
        tick();
        tick();
        // reset state
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_wdata", 32'(fifo_wdata), 0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 0);
        reset = 1'b1;
        tick();

        // 1: single requester, three beats
        set_req(1, 1'b1, 8'hA1, 1'b0);
        #1;
        chk("t1_idle_wr_en", 32'(fifo_wr_en), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        tick();
        chk("t1_grant", 32'(grant_id), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(req_ready), 32'h2);
        chk("t1_wr_en0", 32'(fifo_wr_en), 1);
        chk("t1_wdata0", 32'(fifo_wdata), 32'hA1);
        tick();
        set_req(1, 1'b1, 8'hA2, 1'b0);
        #1;
        chk("t1_wr_en1", 32'(fifo_wr_en), 1);
        chk("t1_wdata1", 32'(fifo_wdata), 32'hA2);
        tick();
        set_req(1, 1'b1, 8'hA3, 1'b1);
        #1;
        chk("t1_wr_en2", 32'(fifo_wr_en), 1);
        chk("t1_wdata2", 32'(fifo_wdata), 32'hA3);
        tick();
        clear_reqs();
        #1;
        chk("t1_end_busy", 32'(busy), 0);
        chk("t1_end_wr_en", 32'(fifo_wr_en), 0);
        chk("t1_end_grant", 32'(grant_id), 1);
        chk("t1_rr_ptr", 32'(dut.rr_ptr), 2);

        // 2: burst limit, req 0 streams 6 beats, req 2 waiting
        do_reset();
        set_req(0, 1'b1, 8'h01, 1'b0);
        set_req(2, 1'b1, 8'hC0, 1'b1);
        #1;
        chk("t2_idle_wr_en", 32'(fifo_wr_en), 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            set_req(0, 1'b1, 8'(8'h01 + b), 1'b0);
            #1;
            chk("t2_grant_a", 32'(grant_id), 0);
            chk("t2_wr_en_a", 32'(fifo_wr_en), 1);
            chk("t2_wdata_a", 32'(fifo_wdata), 32'(1 + b));
            tick();
        end
        set_req(0, 1'b1, 8'h05, 1'b0);
        #1;
        chk("t2_gap_busy", 32'(busy), 0);
        chk("t2_gap_wr_en", 32'(fifo_wr_en), 0);
        chk("t2_gap_rr_ptr", 32'(dut.rr_ptr), 1);
        tick();
        chk("t2_grant_c", 32'(grant_id), 2);
        chk("t2_ready_c", 32'(req_ready), 32'h4);
        chk("t2_wdata_c", 32'(fifo_wdata), 32'hC0);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1;
        chk("t2_gap2_busy", 32'(busy), 0);
        tick();
        chk("t2_grant_b", 32'(grant_id), 0);
        chk("t2_wdata_b0", 32'(fifo_wdata), 32'h05);
        chk("t2_wr_en_b0", 32'(fifo_wr_en), 1);
        tick();
        set_req(0, 1'b1, 8'h06, 1'b1);
        #1;
        chk("t2_wdata_b1", 32'(fifo_wdata), 32'h06);
        chk("t2_wr_en_b1", 32'(fifo_wr_en), 1);
        tick();
        clear_reqs();
        #1;
        chk("t2_end_busy", 32'(busy), 0);

        // 3: round-robin fairness, single-beat bursts
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 1'b1, 8'(8'h30 + i), 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_idle_busy", 32'(busy), 0);
            chk("t3_idle_wr_en", 32'(fifo_wr_en), 0);
            tick();
            chk("t3_grant", 32'(grant_id), 32'(k % 4));
            chk("t3_wdata", 32'(fifo_wdata), 32'(8'h30 + (k % 4)));
            chk("t3_wr_en", 32'(fifo_wr_en), 1);
            tick();
        end
        clear_reqs();
        // rr_ptr is now 1 (last grant was 0)

        // 4: FIFO full mid-burst on req 3
        set_req(3, 1'b1, 8'h10, 1'b0);
        tick();
        chk("t4_grant", 32'(grant_id), 3);
        chk("t4_wr_en0", 32'(fifo_wr_en), 1);
        chk("t4_wdata0", 32'(fifo_wdata), 32'h10);
        tick();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_full_wr_en", 32'(fifo_wr_en), 0);
            chk("t4_full_ready", 32'(req_ready), 0);
            chk("t4_full_grant", 32'(grant_id), 3);
            chk("t4_full_busy", 32'(busy), 1);
            chk("t4_full_cnt", 32'(dut.beat_cnt), 1);
            tick();
        end
        fifo_full = 1'b0;
        set_req(3, 1'b1, 8'h11, 1'b1);
        #1;
        chk("t4_wr_en1", 32'(fifo_wr_en), 1);
        chk("t4_wdata1", 32'(fifo_wdata), 32'h11);
        chk("t4_grant1", 32'(grant_id), 3);
        tick();
        clear_reqs();
        #1;
        chk("t4_end_busy", 32'(busy), 0);
        chk("t4_rr_ptr", 32'(dut.rr_ptr), 0);

        // 5: valid bubble ends the grant
        set_req(1, 1'b1, 8'h55, 1'b0);
        tick();
        chk("t5_grant", 32'(grant_id), 1);
        chk("t5_wdata", 32'(fifo_wdata), 32'h55);
        tick();
        set_req(1, 1'b0, 8'h55, 1'b0);
        #1;
        chk("t5_bubble_wr_en", 32'(fifo_wr_en), 0);
        chk("t5_bubble_busy", 32'(busy), 1);
        tick();
        set_req(1, 1'b1, 8'h56, 1'b1);
        #1;
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_idle_wr_en", 32'(fifo_wr_en), 0);
        chk("t5_rr_ptr", 32'(dut.rr_ptr), 2);
        tick();
        chk("t5_regrant", 32'(grant_id), 1);
        chk("t5_regrant_wdata", 32'(fifo_wdata), 32'h56);
        chk("t5_regrant_wr_en", 32'(fifo_wr_en), 1);
        tick();
        clear_reqs();

        // 6: reset during the 2nd beat of req 0 (rr_ptr is 2 here)
        set_req(0, 1'b1, 8'h70, 1'b0);
        tick();
        tick();
        set_req(0, 1'b1, 8'h71, 1'b0);
        #1;
        chk("t6_beat2_wr_en", 32'(fifo_wr_en), 1);
        chk("t6_beat2_wdata", 32'(fifo_wdata), 32'h71);
        reset = 1'b0;
        #1;
        chk("t6_rst_wr_en", 32'(fifo_wr_en), 0);
        chk("t6_rst_ready", 32'(req_ready), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_grant", 32'(grant_id), 0);
        chk("t6_rst_rr_ptr", 32'(dut.rr_ptr), 0);
        tick();
        chk("t6_rst_hold_wr_en", 32'(fifo_wr_en), 0);
        reset = 1'b1;
        set_req(0, 1'b1, 8'h72, 1'b1);
        set_req(2, 1'b1, 8'h90, 1'b1);
        #1;
        chk("t6_post_idle", 32'(busy), 0);
        tick();
        chk("t6_post_grant", 32'(grant_id), 0);
        chk("t6_post_wdata", 32'(fifo_wdata), 32'h72);
        tick();
        clear_reqs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
